bcd_counter_nd: RTL and testbench
=================================

// Module: bcd_counter_nd
// PURPOSE
//   Parametrised N-digit synchronous BCD counter, the multi-digit successor to the single-digit decade counter.
//   Counts decimal 0..(10^DIGITS-1) with enable, parallel load, wrap or saturate at terminal count,
//   and a cascadable carry-enable-out. Drives display/timer paths and chains into further counters via ceo.
// PARAMETERS
//   DIGITS  4  number of BCD digits (1..8); q width = 4*DIGITS
//   WRAP    1  1: terminal count rolls over; 0: terminal count holds (saturates)
// PORTS
//   clk       in   1          clock, all state on rising edge
//   reset     in   1          synchronous, active-high
//   enable    in   1          count enable (also cascade input from previous stage's ceo)
//   load      in   1          parallel load strobe
//   load_val  in   4*DIGITS   value to load, digit i at [4i+3:4i]
//   up        in   1          direction, 1=up 0=down (present only with BCD_CNT_UPDOWN_EN)
//   q         out  4*DIGITS   counter value, registered
//   ceo       out  1          carry-enable-out, combinational
//   digit_ceo out  DIGITS     per-digit carry-enable chain, combinational
//   load_err  out  1          registered, high one cycle after a load containing a digit > 9
// BEHAVIOUR
//   - Reset value: q = 0, load_err = 0; ceo/digit_ceo follow from q and enable.
//   - Priority per cycle: reset > load > enable > hold.
//   - Load: q <= load_val next edge; any digit > 9 is written as 0; load_err <= 1 if any such digit, else 0.
//     load_err returns to 0 the cycle after unless another bad load occurs. Load ignores enable.
//   - Count (up): digit 0 increments when enable; digit i increments when digit_ceo[i-1]; digit at 9 with
//     incoming enable goes to 0. digit_ceo[i] = incoming enable of digit i & (digit i == 9).
//   - Terminal (up): all digits 9. ceo = enable & terminal = digit_ceo[DIGITS-1].
//   - At terminal with enable: WRAP=1 -> q becomes 0; WRAP=0 -> q holds; ceo asserted in both modes.
//   - Latency: q updates one cycle after enable/load sampled; ceo same cycle as enable (no register),
//     so a chained stage counts in the same edge as the terminal roll.
//   - Digit values > 9 cannot arise except via reset-free X; no recovery logic required beyond load sanitising.
//   - enable & load together: load wins, no count, ceo still reflects enable & terminal of current q.
//   - Reset mid-count or mid-load: reset wins, q = 0, load_err = 0 on that edge.
// CONFIGURATION
//   Macro BCD_CNT_UPDOWN_EN:
//   - Defined: port up present. up=0 counts down: digit at 0 with incoming enable goes to 9; digit_ceo[i] =
//     incoming enable & (digit i == 0); terminal = all digits 0; WRAP=1 -> 0 goes to all 9s, WRAP=0 -> holds at 0.
//     up sampled each cycle; direction change takes effect on the same edge it is sampled.
//   - Undefined: no up port; up-only behaviour above; no down-path logic synthesised.
// STRUCTURE
//   - Shared package bcd_pkg: BCD digit type (4 bits), constants BCD_MAX=4'd9, BCD_MIN=4'd0,
//     function bcd_valid(digit) returning digit <= 9.
//   - Sub-module bcd_digit: one digit register with enable-in, up (when macro), hold-at-terminal input,
//     load/load value, digit carry out. Top generates DIGITS instances and chains digit_ceo.
//   - Top owns load sanitising, load_err register, terminal/WRAP decision.
// TESTING (DIGITS=4, WRAP=1 unless stated)
//   1. reset high 2 cycles, enable=1 -> q=16'h0000, ceo=0, load_err=0 throughout reset.
//   2. load 16'h0998, enable=1 for 3 cycles -> q=0999, 1000, 1001; digit_ceo[2:0]=3'b111 while q=0999.
//   3. load 16'h9999, enable=1 -> ceo=1 that cycle, next q=0000; with WRAP=0 q stays 9999, ceo=1 each enabled cycle.
//   4. load 16'h12A4 -> q=16'h1204, load_err=1 for exactly one cycle; following good load -> load_err=0.
//   5. q=0500, enable=1 and load=1 (16'h0042) same cycle -> q=0042; reset asserted with load -> q=0000.
//   6. BCD_CNT_UPDOWN_EN, up=0: load 16'h1000, enable 2 cycles -> q=0999, 0998; from 0000 with enable
//      -> ceo=1, q=9999 (WRAP=1) or 0000 held (WRAP=0).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and validity helper for the N-digit BCD counter.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;

   function automatic logic bcd_valid(input bcd_digit_t digit);
      return digit <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with cascade enable, load and hold-at-terminal.
// Down counting is present only when BCD_CNT_UPDOWN_EN is defined.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
`ifdef BCD_CNT_UPDOWN_EN
   input  logic       up,
`endif
   input  logic       cin,
   input  logic       hold,
   input  logic       load,
   input  bcd_digit_t load_val,
   output bcd_digit_t q,
   output logic       cout
);

   bcd_digit_t next_val;
   logic       at_limit;

   always_comb begin
      next_val = q;
      at_limit = 1'b0;
`ifdef BCD_CNT_UPDOWN_EN
      if (up) begin
         at_limit = (q == BCD_MAX);
         next_val = at_limit ? BCD_MIN : q + 4'd1;
      end else begin
         at_limit = (q == BCD_MIN);
         next_val = at_limit ? BCD_MAX : q - 4'd1;
      end
`else
      at_limit = (q == BCD_MAX);
      next_val = at_limit ? BCD_MIN : q + 4'd1;
`endif
   end

   assign cout = cin & at_limit;

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= BCD_MIN;
      end else if (load) begin
         q <= load_val;
      end else if (cin && !hold) begin
         q <= next_val;
      end
   end

endmodule

// File: rtl/bcd_counter_nd.sv
// N-digit synchronous BCD counter with load, wrap/saturate and combinational cascade carry.
// Define BCD_CNT_UPDOWN_EN to add the up port and down counting.
module bcd_counter_nd
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned WRAP   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_CNT_UPDOWN_EN
   input  logic                  up,
`endif
   output logic [4*DIGITS-1:0]   q,
   output logic                  ceo,
   output logic [DIGITS-1:0]     digit_ceo,
   output logic                  load_err
);

   logic [4*DIGITS-1:0] load_clean;
   logic                load_bad;
   logic [DIGITS:0]     chain;
   logic                hold;

   // Out-of-range digits are loaded as zero and flagged.
   always_comb begin
      load_clean = '0;
      load_bad   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_valid(load_val[4*i +: 4])) begin
            load_clean[4*i +: 4] = load_val[4*i +: 4];
         end else begin
            load_bad = 1'b1;
         end
      end
   end

   assign chain[0] = enable;
   assign ceo      = chain[DIGITS];
   // Saturating mode freezes every digit when the whole counter sits at terminal.
   assign hold     = (WRAP == 0) ? ceo : 1'b0;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk      (clk),
         .reset    (reset),
`ifdef BCD_CNT_UPDOWN_EN
         .up       (up),
`endif
         .cin      (chain[i]),
         .hold     (hold),
         .load     (load),
         .load_val (load_clean[4*i +: 4]),
         .q        (q[4*i +: 4]),
         .cout     (chain[i+1])
      );
      assign digit_ceo[i] = chain[i+1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         load_err <= 1'b0;
      end else begin
         load_err <= load & load_bad;
      end
   end

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Scoreboard bench for bcd_counter_nd: one wrapping and one saturating DUT driven in lockstep.
module tb_bcd_counter_nd;

   typedef struct {
      string       name;
      logic [15:0] q_w;
      logic [15:0] q_s;
      logic        ceo_w;
      logic        ceo_s;
      logic [3:0]  dc_w;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, enable, load, up;
   logic [15:0] load_val;
   logic [15:0] q_w, q_s;
   logic        ceo_w, ceo_s, err_w, err_s;
   logic [3:0]  dc_w, dc_s;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;

   always #5 clk = ~clk;

   bcd_counter_nd #(.DIGITS(4), .WRAP(1)) u_dut_wrap (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .load      (load),
      .load_val  (load_val),
`ifdef BCD_CNT_UPDOWN_EN
      .up        (up),
`endif
      .q         (q_w),
      .ceo       (ceo_w),
      .digit_ceo (dc_w),
      .load_err  (err_w)
   );

   bcd_counter_nd #(.DIGITS(4), .WRAP(0)) u_dut_sat (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .load      (load),
      .load_val  (load_val),
`ifdef BCD_CNT_UPDOWN_EN
      .up        (up),
`endif
      .q         (q_s),
      .ceo       (ceo_s),
      .digit_ceo (dc_s),
      .load_err  (err_s)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Drive this cycle's inputs and record what the outputs must show before the next edge.
   task automatic cyc(input string nm, input logic rst, input logic en, input logic ld,
                      input logic [15:0] lv, input logic u,
                      input logic [15:0] eqw, input logic [15:0] eqs,
                      input logic ecw, input logic ecs, input logic [3:0] edc,
                      input logic eerr);
      exp_t e;
      reset    = rst;
      enable   = en;
      load     = ld;
      load_val = lv;
      up       = u;
      e.name = nm; e.q_w = eqw; e.q_s = eqs; e.ceo_w = ecw; e.ceo_s = ecs;
      e.dc_w = edc; e.err = eerr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares one expectation per cycle on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.name, ".q_wrap"}, q_w, e.q_w);
         chk({e.name, ".q_sat"}, q_s, e.q_s);
         chk({e.name, ".ceo_wrap"}, {15'd0, ceo_w}, {15'd0, e.ceo_w});
         chk({e.name, ".ceo_sat"}, {15'd0, ceo_s}, {15'd0, e.ceo_s});
         chk({e.name, ".digit_ceo"}, {12'd0, dc_w}, {12'd0, e.dc_w});
         chk({e.name, ".load_err_wrap"}, {15'd0, err_w}, {15'd0, e.err});
         chk({e.name, ".load_err_sat"}, {15'd0, err_s}, {15'd0, e.err});
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b1; load = 1'b0; load_val = '0; up = 1'b1;
      @(posedge clk);
      #1;
      //   name       rst en ld load_val  up  q_wrap    q_sat     cw cs dc       err
      cyc("reset0",   1, 1, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0);
      cyc("reset1",   1, 1, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0);
      cyc("ld0998",   0, 0, 1, 16'h0998, 1, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0);
      cyc("cnt0998",  0, 1, 0, 16'h0000, 1, 16'h0998, 16'h0998, 0, 0, 4'b0000, 0);
      cyc("cnt0999",  0, 1, 0, 16'h0000, 1, 16'h0999, 16'h0999, 0, 0, 4'b0111, 0);
      cyc("cnt1000",  0, 1, 0, 16'h0000, 1, 16'h1000, 16'h1000, 0, 0, 4'b0000, 0);
      cyc("hold1001", 0, 0, 0, 16'h0000, 1, 16'h1001, 16'h1001, 0, 0, 4'b0000, 0);
      cyc("ld9999",   0, 0, 1, 16'h9999, 1, 16'h1001, 16'h1001, 0, 0, 4'b0000, 0);
      cyc("term",     0, 1, 0, 16'h0000, 1, 16'h9999, 16'h9999, 1, 1, 4'b1111, 0);
      cyc("post_trm", 0, 1, 0, 16'h0000, 1, 16'h0000, 16'h9999, 0, 1, 4'b0000, 0);
      cyc("idle_trm", 0, 0, 0, 16'h0000, 1, 16'h0001, 16'h9999, 0, 0, 4'b0000, 0);
      cyc("ld_bad",   0, 0, 1, 16'h12A4, 1, 16'h0001, 16'h9999, 0, 0, 4'b0000, 0);
      cyc("err_hi",   0, 0, 0, 16'h0000, 1, 16'h1204, 16'h1204, 0, 0, 4'b0000, 1);
      cyc("ld_good",  0, 0, 1, 16'h0500, 1, 16'h1204, 16'h1204, 0, 0, 4'b0000, 0);
      cyc("ld_en",    0, 1, 1, 16'h0042, 1, 16'h0500, 16'h0500, 0, 0, 4'b0000, 0);
      cyc("cnt0042",  0, 1, 0, 16'h0000, 1, 16'h0042, 16'h0042, 0, 0, 4'b0000, 0);
      cyc("ld9999b",  0, 0, 1, 16'h9999, 1, 16'h0043, 16'h0043, 0, 0, 4'b0000, 0);
      cyc("ld_term",  0, 1, 1, 16'h0007, 1, 16'h9999, 16'h9999, 1, 1, 4'b1111, 0);
      cyc("rst_ld",   1, 1, 1, 16'h0123, 1, 16'h0007, 16'h0007, 0, 0, 4'b0000, 0);
      cyc("ld_badF",  0, 0, 1, 16'hF000, 1, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0);
      cyc("rst_err",  1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 4'b0000, 1);
      cyc("after_rs", 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0);
`ifdef BCD_CNT_UPDOWN_EN
      cyc("ld1000",   0, 0, 1, 16'h1000, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0);
      cyc("dn1000",   0, 1, 0, 16'h0000, 0, 16'h1000, 16'h1000, 0, 0, 4'b0111, 0);
      cyc("dn0999",   0, 1, 0, 16'h0000, 0, 16'h0999, 16'h0999, 0, 0, 4'b0000, 0);
      cyc("ld0000",   0, 0, 1, 16'h0000, 0, 16'h0998, 16'h0998, 0, 0, 4'b0000, 0);
      cyc("dn_term",  0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1, 4'b1111, 0);
      cyc("dn_post",  0, 0, 0, 16'h0000, 0, 16'h9999, 16'h0000, 0, 0, 4'b0000, 0);
      cyc("dir_chg",  0, 1, 0, 16'h0000, 1, 16'h9999, 16'h0000, 1, 0, 4'b1111, 0);
      cyc("dir_post", 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 0, 0, 4'b0000, 0);
`endif
      stim_done = 1'b1;
   end

   initial begin : finisher
      int budget;
      budget = 0;
      while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0 || !stim_done) begin
         errors++;
         $display("FAIL drain: %0d expectations left, stimulus done %0d, required 0 left and done",
                  exp_q.size(), stim_done);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
